// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial a - b, LSB first, one bit per clock.
// A single borrow flop carries between bits. diff/borrow_out hold
// their value until the next completed operation.
//
// state | meaning
// IDLE  | waiting for start, operands not yet captured
// SHIFT | one difference bit produced per edge
// DONE  | result published, done high for this one cycle
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             diff_bit,
  output logic             bit_valid,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             done
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] res;
  logic [CW-1:0]    cnt;
  logic             br;

  logic d;
  logic br_nxt;
  logic last_bit;

  assign d        = sa[0] ^ sb[0] ^ br;
  assign br_nxt   = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br);
  assign last_bit = (cnt == LAST);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; start is only looked at in IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (last_bit) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decoded straight from the state register.
  always_comb begin
    busy = (state != IDLE);
  end

  // Datapath: operand capture, bit-serial subtract, result publish.
  always_ff @(posedge clk) begin
    if (rst) begin
      sa         <= '0;
      sb         <= '0;
      res        <= '0;
      cnt        <= '0;
      br         <= 1'b0;
      diff_bit   <= 1'b0;
      bit_valid  <= 1'b0;
      diff       <= '0;
      borrow_out <= 1'b0;
      done       <= 1'b0;
    end else begin
      bit_valid <= 1'b0;
      done      <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            sa  <= a;
            sb  <= b;
            br  <= 1'b0;
            cnt <= '0;
          end
        end
        SHIFT: begin
          sa        <= {1'b0, sa[WIDTH-1:1]};
          sb        <= {1'b0, sb[WIDTH-1:1]};
          res       <= {d, res[WIDTH-1:1]};
          br        <= br_nxt;
          cnt       <= cnt + 1'b1;
          diff_bit  <= d;
          bit_valid <= 1'b1;
          if (last_bit) begin
            diff       <= {d, res[WIDTH-1:1]};
            borrow_out <= br_nxt;
            done       <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
